// File: rtl/step_judge.sv
// Arrow judgement stage: grades per-lane arrivals against button presses in
// frame-counted windows, then arbitrates results into combo and BCD score.
module step_judge #(
  parameter int unsigned PERFECT_WIN = 4,
  parameter int unsigned GOOD_WIN    = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        frame_i,
  input  logic [3:0]  arrive_i,
  input  logic [3:0]  btn_i,
  output logic        judge_valid_o,
  output logic [1:0]  judge_o,
  output logic [1:0]  judge_lane_o,
  output logic [7:0]  combo_o,
  output logic [15:0] score_o
);

  localparam logic [1:0] JudgeMiss    = 2'b01;
  localparam logic [1:0] JudgeGood    = 2'b10;
  localparam logic [1:0] JudgePerfect = 2'b11;

  typedef enum logic {StIdle, StArmed} lane_st_e;

  lane_st_e    st_q   [4];
  lane_st_e    st_d   [4];
  logic [5:0]  age_q  [4];
  logic [5:0]  age_d  [4];
  logic [1:0]  res_q  [4];
  logic [1:0]  res_d  [4];
  logic [1:0]  grade_res [4];
  logic [3:0]  grade;
  logic [3:0]  pend_q, pend_d;

  logic        issue;
  logic [1:0]  issue_lane;

  logic        valid_q, valid_d;
  logic [1:0]  judge_q, judge_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  combo_q, combo_d;
  logic [15:0] score_q, score_d;

  // Per-digit BCD add; bit 16 flags overflow past 9999.
  function automatic logic [16:0] bcd_add(input logic [15:0] s, input logic [1:0] inc);
    logic [16:0] r;
    logic [4:0]  d;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = {1'b0, s[4*k +: 4]} + ((k == 0) ? {3'b000, inc} : 5'd0) + {4'd0, c};
      if (d > 5'd9) begin
        d = d - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*k +: 4] = d[3:0];
    end
    r[16] = c;
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      st_d[i]      = st_q[i];
      age_d[i]     = age_q[i];
      grade[i]     = 1'b0;
      grade_res[i] = JudgeMiss;
      if (clr_i) begin
        st_d[i]  = StIdle;
        age_d[i] = '0;
      end else begin
        unique case (st_q[i])
          StIdle: begin
            if (arrive_i[i]) begin
              if (btn_i[i]) begin
                // Arrival and press together count as an age-0 hit.
                grade[i]     = 1'b1;
                grade_res[i] = JudgePerfect;
              end else begin
                st_d[i]  = StArmed;
                age_d[i] = '0;
              end
            end
          end
          StArmed: begin
            if (btn_i[i]) begin
              grade[i]     = 1'b1;
              grade_res[i] = (age_q[i] < 6'(PERFECT_WIN)) ? JudgePerfect : JudgeGood;
              st_d[i]      = arrive_i[i] ? StArmed : StIdle;
              age_d[i]     = '0;
            end else if (arrive_i[i]) begin
              grade[i]     = 1'b1;
              grade_res[i] = JudgeMiss;
              age_d[i]     = '0;
            end else if (frame_i) begin
              if (age_q[i] + 6'd1 == 6'(GOOD_WIN)) begin
                grade[i]     = 1'b1;
                grade_res[i] = JudgeMiss;
                st_d[i]      = StIdle;
                age_d[i]     = '0;
              end else begin
                age_d[i] = age_q[i] + 6'd1;
              end
            end
          end
          default: begin
            st_d[i]  = StIdle;
            age_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Fixed priority: ascending scan so lane 3 wins.
  always_comb begin
    issue      = 1'b0;
    issue_lane = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (pend_q[i]) begin
        issue      = 1'b1;
        issue_lane = 2'(i);
      end
    end
  end

  always_comb begin
    pend_d = '0;
    for (int i = 0; i < 4; i++) begin
      res_d[i] = grade[i] ? grade_res[i] : res_q[i];
      if (!clr_i) begin
        pend_d[i] = (pend_q[i] && !(issue && issue_lane == 2'(i))) || grade[i];
      end
    end
  end

  always_comb begin
    logic [16:0] sum;
    logic [1:0]  inc;
    valid_d = 1'b0;
    judge_d = 2'b00;
    lane_d  = 2'd0;
    combo_d = combo_q;
    score_d = score_q;
    inc     = 2'd0;
    sum     = '0;
    if (clr_i) begin
      combo_d = '0;
      score_d = '0;
    end else if (issue) begin
      valid_d = 1'b1;
      judge_d = res_q[issue_lane];
      lane_d  = issue_lane;
      unique case (res_q[issue_lane])
        JudgePerfect: inc = 2'd2;
        JudgeGood:    inc = 2'd1;
        default:      inc = 2'd0;
      endcase
      if (res_q[issue_lane] == JudgeMiss) begin
        combo_d = '0;
      end else if (combo_q != 8'd255) begin
        combo_d = combo_q + 8'd1;
      end
      sum     = bcd_add(score_q, inc);
      score_d = sum[16] ? 16'h9999 : sum[15:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= StIdle;
        age_q[i] <= '0;
        res_q[i] <= '0;
      end
      pend_q  <= '0;
      valid_q <= 1'b0;
      judge_q <= 2'b00;
      lane_q  <= 2'd0;
      combo_q <= '0;
      score_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= st_d[i];
        age_q[i] <= age_d[i];
        res_q[i] <= res_d[i];
      end
      pend_q  <= pend_d;
      valid_q <= valid_d;
      judge_q <= judge_d;
      lane_q  <= lane_d;
      combo_q <= combo_d;
      score_q <= score_d;
    end
  end

  assign judge_valid_o = valid_q;
  assign judge_o       = judge_q;
  assign judge_lane_o  = lane_q;
  assign combo_o       = combo_q;
  assign score_o       = score_q;

endmodule

// File: tb/tb_step_judge.sv
// Directed bench for step_judge: grading windows, arbitration order, combo and
// BCD score saturation, reset and clear behaviour.
module tb_step_judge;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        frame;
  logic [3:0]  arrive;
  logic [3:0]  btn;
  logic        judge_valid;
  logic [1:0]  judge;
  logic [1:0]  judge_lane;
  logic [7:0]  combo;
  logic [15:0] score;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int seen   = 0;
  int seen0;

  step_judge #(
    .PERFECT_WIN(4),
    .GOOD_WIN   (10)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (clr),
    .frame_i      (frame),
    .arrive_i     (arrive),
    .btn_i        (btn),
    .judge_valid_o(judge_valid),
    .judge_o      (judge),
    .judge_lane_o (judge_lane),
    .combo_o      (combo),
    .score_o      (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are held across exactly one rising edge, then outputs sampled 1ns later.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic f, input logic c);
    arrive = a;
    btn    = b;
    frame  = f;
    clr    = c;
    @(posedge clk);
    #1;
    arrive = '0;
    btn    = '0;
    frame  = 1'b0;
    clr    = 1'b0;
    if (judge_valid) seen++;
  endtask

  task automatic tick();
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n  = 1'b0;
    clr    = 1'b0;
    frame  = 1'b0;
    arrive = '0;
    btn    = '0;
    #12;
    chk("rst_valid", 16'(judge_valid), 16'd0);
    chk("rst_judge", 16'(judge), 16'd0);
    chk("rst_lane", 16'(judge_lane), 16'd0);
    chk("rst_combo", 16'(combo), 16'd0);
    chk("rst_score", score, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // PERFECT at age 2 on lane 3
    step(4'b1000, 4'b0000, 1'b0, 1'b0);
    frames(2);
    step(4'b0000, 4'b1000, 1'b0, 1'b0);
    chk("perf_pre_valid", 16'(judge_valid), 16'd0);
    tick();
    chk("perf_valid", 16'(judge_valid), 16'd1);
    chk("perf_judge", 16'(judge), 16'd3);
    chk("perf_lane", 16'(judge_lane), 16'd3);
    chk("perf_combo", 16'(combo), 16'd1);
    chk("perf_score", score, 16'h0002);
    tick();
    chk("perf_drop_valid", 16'(judge_valid), 16'd0);
    chk("perf_drop_judge", 16'(judge), 16'd0);

    // GOOD at age 5 on lane 0
    step(4'b0001, 4'b0000, 1'b0, 1'b0);
    frames(5);
    step(4'b0000, 4'b0001, 1'b0, 1'b0);
    tick();
    chk("good_judge", 16'(judge), 16'd2);
    chk("good_lane", 16'(judge_lane), 16'd0);
    chk("good_combo", 16'(combo), 16'd2);
    chk("good_score", score, 16'h0003);

    // MISS on the 10th frame
    step(4'b0001, 4'b0000, 1'b0, 1'b0);
    seen0 = seen;
    frames(10);
    chk("miss_early", 16'(seen - seen0), 16'd0);
    tick();
    chk("miss_valid", 16'(judge_valid), 16'd1);
    chk("miss_judge", 16'(judge), 16'd1);
    chk("miss_combo", 16'(combo), 16'd0);
    chk("miss_score", score, 16'h0003);

    // Clear, then all four lanes hit at age 0
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("clr_score", score, 16'h0000);
    step(4'b1111, 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sim_valid", 16'(judge_valid), 16'd1);
      chk("sim_lane", 16'(judge_lane), 16'(3 - i));
      chk("sim_judge", 16'(judge), 16'd3);
    end
    chk("sim_combo", 16'(combo), 16'd4);
    chk("sim_score", score, 16'h0008);
    tick();
    chk("sim_done", 16'(judge_valid), 16'd0);

    // Stray press in IDLE
    seen0 = seen;
    step(4'b0000, 4'b0100, 1'b0, 1'b0);
    tick();
    tick();
    chk("stray_none", 16'(seen - seen0), 16'd0);
    chk("stray_combo", 16'(combo), 16'd4);

    // Press with frame at age PERFECT_WIN-1
    step(4'b0010, 4'b0000, 1'b0, 1'b0);
    frames(3);
    step(4'b0000, 4'b0010, 1'b1, 1'b0);
    tick();
    chk("edge_judge", 16'(judge), 16'd3);
    chk("edge_lane", 16'(judge_lane), 16'd1);
    chk("edge_score", score, 16'h0010);

    // Re-arrive while ARMED
    step(4'b0100, 4'b0000, 1'b0, 1'b0);
    frames(1);
    step(4'b0100, 4'b0000, 1'b0, 1'b0);
    tick();
    chk("rearr_judge", 16'(judge), 16'd1);
    chk("rearr_lane", 16'(judge_lane), 16'd2);
    chk("rearr_combo", 16'(combo), 16'd0);
    step(4'b0000, 4'b0100, 1'b0, 1'b0);
    tick();
    chk("rearr_new_judge", 16'(judge), 16'd3);
    chk("rearr_new_score", score, 16'h0012);

    // BCD carry: 99 GOODs then a PERFECT
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 99; i++) begin
      step(4'b0001, 4'b0000, 1'b0, 1'b0);
      frames(4);
      step(4'b0000, 4'b0001, 1'b0, 1'b0);
      tick();
    end
    chk("bcd_99", score, 16'h0099);
    chk("bcd_combo99", 16'(combo), 16'd99);
    step(4'b0001, 4'b0001, 1'b0, 1'b0);
    tick();
    chk("bcd_101", score, 16'h0101);

    // Score and combo saturation
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 1249; i++) begin
      step(4'b1111, 4'b1111, 1'b0, 1'b0);
      repeat (4) tick();
    end
    chk("sat_combo", 16'(combo), 16'd255);
    chk("sat_9992", score, 16'h9992);
    for (int i = 0; i < 3; i++) begin
      step(4'b1000, 4'b1000, 1'b0, 1'b0);
      tick();
    end
    chk("sat_9998", score, 16'h9998);
    step(4'b1000, 4'b1000, 1'b0, 1'b0);
    tick();
    chk("sat_9999", score, 16'h9999);
    step(4'b1000, 4'b1000, 1'b0, 1'b0);
    tick();
    chk("sat_hold", score, 16'h9999);
    chk("sat_combo_hold", 16'(combo), 16'd255);

    // Asynchronous reset mid-window
    step(4'b1000, 4'b0000, 1'b0, 1'b0);
    frames(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_combo", 16'(combo), 16'd0);
    chk("arst_score", score, 16'h0000);
    chk("arst_valid", 16'(judge_valid), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen0 = seen;
    frames(12);
    chk("arst_no_miss", 16'(seen - seen0), 16'd0);

    // Synchronous clear mid-window
    step(4'b1001, 4'b1000, 1'b0, 1'b0);
    tick();
    chk("clr_pre_score", score, 16'h0002);
    frames(1);
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("clr_combo", 16'(combo), 16'd0);
    chk("clr_score2", score, 16'h0000);
    chk("clr_valid", 16'(judge_valid), 16'd0);
    seen0 = seen;
    frames(12);
    chk("clr_no_miss", 16'(seen - seen0), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
